// File: rtl/freq_gen_pkg.sv
// Shared types and default widths for the pulse-train generator.
package freq_gen_pkg;

  // Default phase-length width (matches the measurement divider's duration width).
  localparam int LEN_W_DEF = 16;
  // Default pulse-count width.
  localparam int CNT_W_DEF = 8;

  // Generator FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } gen_state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter shared by the HIGH and LOW phases.
// A load takes priority over counting; the count holds at zero rather than
// wrapping, so the controller can reload it on the cycle it sees zero.
module phase_counter #(
  parameter int LEN_W = 16
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [LEN_W-1:0] load_val,
  output logic [LEN_W-1:0] value,
  output logic             zero
);

  logic [LEN_W-1:0] cnt_q;

  // Count register: load wins, otherwise decrement while enabled and non-zero.
  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/freq_pulse_gen.sv
// Programmable pulse-train generator timed in RefClk cycles.
// A pulse is a HIGH phase of high_len+1 cycles followed by a LOW phase of
// low_len+1 cycles, repeated num_pulses times (0 = until stop).
// All outputs come straight from registers; inputs never reach outputs
// combinationally.
module freq_pulse_gen
  import freq_gen_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             OutFreq,
  output logic             busy,
  output logic             complete,
  output logic [CNT_W-1:0] pulse_cnt,
  output gen_state_t       fsm_state
);

  gen_state_t       state_q, state_d;

  // Parameters captured on an accepted start; mid-burst input changes are ignored.
  logic [LEN_W-1:0] high_q, low_q;
  logic [CNT_W-1:0] num_q;

  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             comp_q, comp_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             latch;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [LEN_W-1:0] cnt_val, cnt_value;

  // One bit wider than pulse_cnt so the final-pulse compare cannot match on wrap.
  logic [CNT_W:0]   pcnt_inc;
  logic             last_pulse;

  assign pcnt_inc   = {1'b0, pcnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_pulse = (num_q != '0) && (pcnt_inc == {1'b0, num_q});

  phase_counter #(.LEN_W(LEN_W)) u_phase_counter (
    .RefClk   (RefClk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // Next-state and next-register decode; every target defaults to "hold".
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    busy_d   = busy_q;
    comp_d   = comp_q;
    pcnt_d   = pcnt_q;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = high_q;
    unique case (state_q)
      IDLE: begin
        // stop dominates start, and stop alone leaves complete untouched.
        if (start && !stop) begin
          latch    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = high_len;
          pcnt_d   = '0;
          comp_d   = 1'b0;
          out_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (stop) begin
          out_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = low_q;
          out_d    = 1'b0;
          state_d  = LOW;
        end else begin
          cnt_en = 1'b1;
        end
      end
      LOW: begin
        if (stop) begin
          out_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_zero) begin
          pcnt_d = pcnt_inc[CNT_W-1:0];
          if (last_pulse) begin
            busy_d  = 1'b0;
            comp_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = high_q;
            out_d    = 1'b1;
            state_d  = HIGH;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        out_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, latched parameters and output registers; reset is asynchronous.
  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      comp_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      comp_q  <= comp_d;
      pcnt_q  <= pcnt_d;
      if (latch) begin
        high_q <= high_len;
        low_q  <= low_len;
        num_q  <= num_pulses;
      end
    end
  end

  assign OutFreq   = out_q;
  assign busy      = busy_q;
  assign complete  = comp_q;
  assign pulse_cnt = pcnt_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_freq_pulse_gen.sv
// Self-checking bench for freq_pulse_gen: expected OutFreq waveforms are
// queued from the burst parameters and compared cycle by cycle.
module tb_freq_pulse_gen;
  import freq_gen_pkg::*;

  localparam int LEN_W = 16;
  localparam int CNT_W = 8;

  logic             RefClk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic [CNT_W-1:0] num_pulses;
  logic             OutFreq;
  logic             busy;
  logic             complete;
  logic [CNT_W-1:0] pulse_cnt;
  gen_state_t       fsm_state;

  int vec_cnt  = 0;
  int err_cnt  = 0;

  logic [0:0] exp_q[$];

  freq_pulse_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .RefClk     (RefClk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .OutFreq    (OutFreq),
    .busy       (busy),
    .complete   (complete),
    .pulse_cnt  (pulse_cnt),
    .fsm_state  (fsm_state)
  );

  // Clock
  initial RefClk = 1'b0;
  always #5 RefClk = ~RefClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; all driving and sampling happens here.
  task automatic tick();
    @(posedge RefClk);
    #1;
  endtask

  // Queue the ideal waveform for n pulses, starting at the first HIGH cycle.
  task automatic push_wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i <= h; i++) exp_q.push_back(1'b1);
      for (int i = 0; i <= l; i++) exp_q.push_back(1'b0);
    end
  endtask

  task automatic drain();
    logic [0:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_freq", {31'd0, OutFreq}, {31'd0, e});
      tick();
    end
  endtask

  // Drive an accepted start; returns just after the edge where OutFreq rises.
  task automatic do_start(input int h, input int l, input int n);
    high_len   = LEN_W'(h);
    low_len    = LEN_W'(l);
    num_pulses = CNT_W'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic run_burst(input int h, input int l, input int n);
    do_start(h, l, n);
    check("busy_run", {31'd0, busy}, 32'd1);
    push_wave(h, l, n);
    drain();
    check("done_complete", {31'd0, complete}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_out", {31'd0, OutFreq}, 32'd0);
    check("done_pcnt", {24'd0, pulse_cnt}, n);
  endtask

  // Stimulus and checking
  initial begin
    int hi_cycles;
    int guard;
    int h, l, n;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    high_len = '0; low_len = '0; num_pulses = '0;
    #12;
    check("rst_out", {31'd0, OutFreq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_complete", {31'd0, complete}, 32'd0);
    check("rst_pcnt", {24'd0, pulse_cnt}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of a long HIGH phase.
    do_start(100, 7, 1);
    repeat (9) tick();
    check("pre_rst_out", {31'd0, OutFreq}, 32'd1);
    rst = 1'b1;
    #2;
    check("arst_out", {31'd0, OutFreq}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    #1 rst = 1'b0;
    tick();

    // Two short pulses: 1111 00 1111 00.
    run_burst(3, 1, 2);

    // Loopback-style high-time measurement: duration = high cycles - 1.
    do_start(9, 4, 1);
    hi_cycles = 0;
    guard = 0;
    while (OutFreq === 1'b1 && guard < 1000) begin
      hi_cycles++;
      guard++;
      tick();
    end
    check("loop_duration", hi_cycles - 1, 32'd9);
    guard = 0;
    while (complete !== 1'b1 && guard < 1000) begin
      guard++;
      tick();
    end
    check("loop_complete", {31'd0, complete}, 32'd1);
    check("loop_pcnt", {24'd0, pulse_cnt}, 32'd1);

    // stop alone in IDLE keeps complete.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_complete", {31'd0, complete}, 32'd1);

    // Continuous 1-cycle phases: pulse_cnt wraps after 256 pulses.
    do_start(0, 0, 0);
    check("cont_complete_clr", {31'd0, complete}, 32'd0);
    push_wave(0, 0, 1);
    drain();
    check("cont_pcnt_1", {24'd0, pulse_cnt}, 32'd1);
    push_wave(0, 0, 255);
    drain();
    check("cont_pcnt_wrap", {24'd0, pulse_cnt}, 32'd0);
    check("cont_busy", {31'd0, busy}, 32'd1);
    check("cont_out_high", {31'd0, OutFreq}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_stop_out", {31'd0, OutFreq}, 32'd0);
    check("cont_stop_busy", {31'd0, busy}, 32'd0);
    check("cont_stop_complete", {31'd0, complete}, 32'd0);

    // stop sampled at the end of LOW cycle 2 of the first pulse.
    do_start(5, 5, 3);
    push_wave(5, 5, 1);
    while (exp_q.size() > 5) begin
      check("stop_wave", {31'd0, OutFreq}, {31'd0, exp_q.pop_front()});
      tick();
    end
    exp_q.delete();
    check("stop_low2_out", {31'd0, OutFreq}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_state", {30'd0, fsm_state}, {30'd0, IDLE});
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_pcnt", {24'd0, pulse_cnt}, 32'd0);
    check("stop_complete", {31'd0, complete}, 32'd0);
    repeat (3) tick();
    check("stop_stays_low", {31'd0, OutFreq}, 32'd0);

    // start re-pulsed and high_len changed mid-burst: original timing kept.
    do_start(4, 2, 2);
    push_wave(4, 2, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 3) begin
        start = 1'b1;
        high_len = LEN_W'(50);
      end
      if (i == 9) start = 1'b0;
      check("ignore_wave", {31'd0, OutFreq}, {31'd0, exp_q.pop_front()});
      tick();
    end
    start = 1'b0;
    check("ignore_complete", {31'd0, complete}, 32'd1);
    check("ignore_pcnt", {24'd0, pulse_cnt}, 32'd2);

    // start and stop together in IDLE: nothing changes.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("both_state", {30'd0, fsm_state}, {30'd0, IDLE});
    check("both_out", {31'd0, OutFreq}, 32'd0);
    check("both_complete", {31'd0, complete}, 32'd1);
    check("both_pcnt", {24'd0, pulse_cnt}, 32'd2);

    // A few randomised finite bursts.
    for (int k = 0; k < 4; k++) begin
      h = $urandom_range(0, 6);
      l = $urandom_range(0, 6);
      n = $urandom_range(1, 3);
      run_burst(h, l, n);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
